// File: rtl/vga_pattern_gen.sv
// Purpose: VGA test-pattern generator (bands, scrolling bands, checker, colour cycle); border overlay when VGA_PATTERN_BORDER_EN is defined.
// Latency: 1 cycle from iVGA_X/iVGA_Y/iMode to colour outputs; mode, frame count and scroll change only at frame start.
// Backpressure: none; free-running on the pixel clock, one pixel in and one pixel out every cycle.
module vga_pattern_gen #(
  parameter int COLOR_W    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int NUM_BARS   = 16,
  parameter int BAR_W      = 40,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic [9:0]         iVGA_X,
  input  logic [9:0]         iVGA_Y,
  input  logic [1:0]         iMode,
  input  logic               iScroll_En,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic [1:0]         oMode,
  output logic [7:0]         oFrame_Cnt
);

  localparam int BAR_BITS = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int PH_BITS  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [PH_BITS-1:0]  PH_LAST  = PH_BITS'(BAR_W - 1);
  localparam logic [PH_BITS-1:0]  PH_ONE   = PH_BITS'(1);
  localparam logic [BAR_BITS-1:0] BAR_LAST = BAR_BITS'(NUM_BARS - 1);
  localparam logic [BAR_BITS-1:0] BAR_ONE  = BAR_BITS'(1);

  localparam logic [9:0] X_END  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_END  = 10'(V_ACTIVE);
  localparam logic [9:0] BAND_1 = 10'((1 * V_ACTIVE) / 4);
  localparam logic [9:0] BAND_2 = 10'((2 * V_ACTIVE) / 4);
  localparam logic [9:0] BAND_3 = 10'((3 * V_ACTIVE) / 4);
`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
`endif

  localparam logic [COLOR_W-1:0] FULL = '1;

  typedef enum logic [1:0] {
    MODE_BANDS   = 2'd0,
    MODE_SCROLL  = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_CYCLE   = 2'd3
  } mode_e;

  // Bar index replicated MSB-first across the colour width: 0 -> 0, last bar -> all ones.
  function automatic logic [COLOR_W-1:0] barLevel(input logic [BAR_BITS-1:0] b);
    logic [COLOR_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      lvl[COLOR_W-1-i] = b[BAR_BITS-1-(i % BAR_BITS)];
    end
    return lvl;
  endfunction

  // Frame count placed in the colour MSBs, zero-padded below or truncated from the bottom.
  function automatic logic [COLOR_W-1:0] cycleLevel(input logic [7:0] c);
    logic [COLOR_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      if (i < 8) begin
        lvl[COLOR_W-1-i] = c[7-i];
      end
    end
    return lvl;
  endfunction

  // Frame-level state
  logic                prevOrigin;
  logic [PH_BITS-1:0]  scrollPhase;
  logic [BAR_BITS-1:0] scrollBar;

  // Running pixel counter for the current line
  logic [PH_BITS-1:0]  pixPhase;
  logic [BAR_BITS-1:0] pixBar;

  // Next-state values
  logic                isOrigin;
  logic                frameStart;
  mode_e               modeNext;
  logic [7:0]          cntNext;
  logic [PH_BITS-1:0]  scrollPhaseNext;
  logic [BAR_BITS-1:0] scrollBarNext;
  logic [PH_BITS-1:0]  pixPhaseNext;
  logic [BAR_BITS-1:0] pixBarNext;
  logic [COLOR_W-1:0]  redNext;
  logic [COLOR_W-1:0]  greenNext;
  logic [COLOR_W-1:0]  blueNext;

  logic                active;
  logic [1:0]          band;
  logic [COLOR_W-1:0]  lvl;
  logic [COLOR_W-1:0]  invLvl;

  // Detect frame start and derive the mode, count and scroll offset that the new frame uses.
  // The frame-start pixel itself already sees the new values, so the whole frame is consistent.
  always_comb begin
    isOrigin        = (iVGA_X == 10'd0) && (iVGA_Y == 10'd0);
    frameStart      = isOrigin && !prevOrigin;
    modeNext        = mode_e'(oMode);
    cntNext         = oFrame_Cnt;
    scrollPhaseNext = scrollPhase;
    scrollBarNext   = scrollBar;
    if (frameStart) begin
      modeNext = mode_e'(iMode);
      cntNext  = oFrame_Cnt + 8'd1;
      if (iScroll_En) begin
        if (scrollPhase == PH_LAST) begin
          scrollPhaseNext = '0;
          scrollBarNext   = scrollBar + BAR_ONE;
        end else begin
          scrollPhaseNext = scrollPhase + PH_ONE;
        end
      end
    end
  end

  // Advance the pixel counter along the line; reload it from the scroll offset at X==0.
  // BANDS mode always starts the line at bar 0 so it ignores the scroll offset.
  always_comb begin
    pixPhaseNext = pixPhase;
    pixBarNext   = pixBar;
    if (iVGA_X == 10'd0) begin
      if (modeNext == MODE_BANDS) begin
        pixPhaseNext = '0;
        pixBarNext   = '0;
      end else begin
        pixPhaseNext = scrollPhaseNext;
        pixBarNext   = scrollBarNext;
      end
    end else if (iVGA_X < X_END) begin
      if (pixPhase == PH_LAST) begin
        pixPhaseNext = '0;
        pixBarNext   = pixBar + BAR_ONE;
      end else begin
        pixPhaseNext = pixPhase + PH_ONE;
      end
    end
  end

  // Pick the row band and the forward/inverted bar levels for the current pixel.
  always_comb begin
    active = (iVGA_X < X_END) && (iVGA_Y < Y_END);
    if (iVGA_Y < BAND_1) begin
      band = 2'd0;
    end else if (iVGA_Y < BAND_2) begin
      band = 2'd1;
    end else if (iVGA_Y < BAND_3) begin
      band = 2'd2;
    end else begin
      band = 2'd3;
    end
    lvl    = barLevel(pixBarNext);
    invLvl = barLevel(BAR_LAST - pixBarNext);
  end

  // Select the colour for the current pixel from the mode in effect; blanking forces black.
  always_comb begin
    redNext   = '0;
    greenNext = '0;
    blueNext  = '0;
    if (active) begin
      case (modeNext)
        MODE_BANDS, MODE_SCROLL: begin
          case (band)
            2'd0: redNext   = lvl;
            2'd1: greenNext = invLvl;
            2'd2: blueNext  = lvl;
            default: begin
              redNext   = invLvl;
              greenNext = invLvl;
              blueNext  = invLvl;
            end
          endcase
        end
        MODE_CHECKER: begin
          if (iVGA_X[CHECK_LOG2] ^ iVGA_Y[CHECK_LOG2]) begin
            redNext   = FULL;
            greenNext = FULL;
            blueNext  = FULL;
          end
        end
        default: begin
          redNext   = cycleLevel(cntNext);
          greenNext = cycleLevel(cntNext);
          blueNext  = cycleLevel(cntNext);
        end
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      // Border pixels override every mode.
      if ((iVGA_X == 10'd0) || (iVGA_X == X_LAST) ||
          (iVGA_Y == 10'd0) || (iVGA_Y == Y_LAST)) begin
        redNext   = FULL;
        greenNext = FULL;
        blueNext  = FULL;
      end
`endif
    end
  end

  // Register outputs and all frame/line state; reset clears everything, including the mode.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oMode       <= 2'd0;
      oFrame_Cnt  <= 8'd0;
      prevOrigin  <= 1'b0;
      scrollPhase <= '0;
      scrollBar   <= '0;
      pixPhase    <= '0;
      pixBar      <= '0;
    end else begin
      oRed        <= redNext;
      oGreen      <= greenNext;
      oBlue       <= blueNext;
      oMode       <= modeNext;
      oFrame_Cnt  <= cntNext;
      prevOrigin  <= isOrigin;
      scrollPhase <= scrollPhaseNext;
      scrollBar   <= scrollBarNext;
      pixPhase    <= pixPhaseNext;
      pixBar      <= pixBarNext;
    end
  end

endmodule
